// File: rtl/moquanmips_if_stage.sv
// Instruction-fetch stage: program counter, ROM address/enable, and the IF/ID
// pipeline register, with stall, flush redirect and stalled-branch capture.
module moquanmips_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        flush,
    input  logic [31:0] new_pc_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] rom_inst_i,
    output logic [31:0] rom_addr_o,
    output logic        rom_ce_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o,
    output logic        id_adel_o
);

    logic        [31:0] pc_p0;
    logic        [31:0] pc_nxt;
    logic               ce_p0;
    logic               pend_flag;
    logic               pend_flag_nxt;
    logic        [31:0] pend_target;
    logic        [31:0] pend_target_nxt;

    logic        [31:0] id_pc_p1;
    logic        [31:0] id_inst_p1;
    logic               vld_p1;
    logic               id_adel_p1;
    logic        [31:0] id_pc_nxt;
    logic        [31:0] id_inst_nxt;
    logic               vld_nxt;
    logic               id_adel_nxt;
    logic               fetch_adel;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

    assign fetch_adel = misaligned(pc_p0);

    // ---- stage p0: PC selection and branch capture while stalled ----
    always_comb begin
        pc_nxt          = pc_p0;
        pend_flag_nxt   = pend_flag;
        pend_target_nxt = pend_target;
        if (!ce_p0) begin
            pc_nxt = RESET_PC;
        end else if (flush) begin
            pc_nxt        = new_pc_i;
            pend_flag_nxt = 1'b0;
        end else if (stall_if) begin
            // A later branch during the same stall overwrites an earlier one.
            if (branch_flag_i) begin
                pend_flag_nxt   = 1'b1;
                pend_target_nxt = branch_target_i;
            end
        end else if (branch_flag_i) begin
            pc_nxt        = branch_target_i;
            pend_flag_nxt = 1'b0;
        end else if (pend_flag) begin
            pc_nxt        = pend_target;
            pend_flag_nxt = 1'b0;
        end else begin
            pc_nxt = pc_p0 + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_p0       <= RESET_PC;
            ce_p0       <= 1'b0;
            pend_flag   <= 1'b0;
            pend_target <= 32'h0;
        end else begin
            pc_p0       <= pc_nxt;
            ce_p0       <= 1'b1;
            pend_flag   <= pend_flag_nxt;
            pend_target <= pend_target_nxt;
        end
    end

    // ---- stage p1: IF/ID register ----
    always_comb begin
        id_pc_nxt   = id_pc_p1;
        id_inst_nxt = id_inst_p1;
        vld_nxt     = vld_p1;
        id_adel_nxt = id_adel_p1;
        if (flush || (!stall_id && (stall_if || !ce_p0))) begin
            id_pc_nxt   = 32'h0;
            id_inst_nxt = 32'h0;
            vld_nxt     = 1'b0;
            id_adel_nxt = 1'b0;
        end else if (!stall_id) begin
            // Misaligned fetches still drive the address but deliver a nop word.
            id_pc_nxt   = pc_p0;
            id_inst_nxt = fetch_adel ? 32'h0 : rom_inst_i;
            vld_nxt     = 1'b1;
            id_adel_nxt = fetch_adel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_pc_p1   <= 32'h0;
            id_inst_p1 <= 32'h0;
            vld_p1     <= 1'b0;
            id_adel_p1 <= 1'b0;
        end else begin
            id_pc_p1   <= id_pc_nxt;
            id_inst_p1 <= id_inst_nxt;
            vld_p1     <= vld_nxt;
            id_adel_p1 <= id_adel_nxt;
        end
    end

    assign rom_addr_o = pc_p0;
    assign rom_ce_o   = ce_p0;
    assign id_pc_o    = id_pc_p1;
    assign id_inst_o  = id_inst_p1;
    assign id_valid_o = vld_p1;
    assign id_adel_o  = id_adel_p1;

endmodule

// File: tb/tb_moquanmips_if_stage.sv
// Scoreboard bench for moquanmips_if_stage: each scenario queues per-cycle
// stimulus with the expected fetch/IF-ID state, then drains and compares it.
module tb_moquanmips_if_stage;

    logic        clk;
    logic        rst;
    logic        stall_if;
    logic        stall_id;
    logic        flush;
    logic [31:0] new_pc_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic [31:0] rom_inst_i;
    logic [31:0] rom_addr_o;
    logic        rom_ce_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;
    logic        id_adel_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        sif;
        logic        sid;
        logic        fl;
        logic [31:0] npc;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_vld;
        logic        e_adel;
    } step_t;

    step_t q[$];

    moquanmips_if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .flush           (flush),
        .new_pc_i        (new_pc_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .rom_inst_i      (rom_inst_i),
        .rom_addr_o      (rom_addr_o),
        .rom_ce_o        (rom_ce_o),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o),
        .id_valid_o      (id_valid_o),
        .id_adel_o       (id_adel_o)
    );

    // ROM model: each word equals its own address.
    assign rom_inst_i = rom_addr_o;

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic add(input logic sif, input logic sid, input logic fl,
                       input logic [31:0] npc, input logic br, input logic [31:0] tgt,
                       input logic [31:0] ea, input logic [31:0] ep, input logic [31:0] ei,
                       input logic ev, input logic ead);
        step_t s;
        s.sif = sif; s.sid = sid; s.fl = fl; s.npc = npc; s.br = br; s.tgt = tgt;
        s.e_addr = ea; s.e_pc = ep; s.e_inst = ei; s.e_vld = ev; s.e_adel = ead;
        q.push_back(s);
    endtask

    task automatic idle_inputs();
        stall_if = 0; stall_id = 0; flush = 0; new_pc_i = 0;
        branch_flag_i = 0; branch_target_i = 0;
    endtask

    task automatic test_reset();
        step_t s;
        rst = 1'b0;
        idle_inputs();
        #20;
        total++;
        if ({rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o} !== 67'h0) begin
            bad++;
            $display("FAIL reset_hold: got addr=%h ce=%b pc=%h inst=%h v=%b adel=%b want all 0",
                     rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o);
        end
        #175 rst = 1'b1;
        #1;
        total++;
        if (rom_ce_o !== 1'b0) begin
            bad++;
            $display("FAIL ce_before_edge: got ce=%b want 0", rom_ce_o);
        end
        add(0,0,0,0,0,0, 32'h00, 32'h00, 32'h00, 0, 0);
        add(0,0,0,0,0,0, 32'h04, 32'h00, 32'h00, 1, 0);
        add(0,0,0,0,0,0, 32'h08, 32'h04, 32'h04, 1, 0);
        add(0,0,0,0,0,0, 32'h0C, 32'h08, 32'h08, 1, 0);
        add(0,0,0,0,0,0, 32'h10, 32'h0C, 32'h0C, 1, 0);
        while (q.size() > 0) begin
            s = q.pop_front();
            stall_if = s.sif; stall_id = s.sid; flush = s.fl; new_pc_i = s.npc;
            branch_flag_i = s.br; branch_target_i = s.tgt;
            @(posedge clk); #1;
            total++;
            if ({rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o} !==
                {s.e_addr, 1'b1, s.e_pc, s.e_inst, s.e_vld, s.e_adel}) begin
                bad++;
                $display("FAIL startup: got addr=%h ce=%b pc=%h inst=%h v=%b adel=%b want addr=%h pc=%h inst=%h v=%b adel=%b",
                         rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o,
                         s.e_addr, s.e_pc, s.e_inst, s.e_vld, s.e_adel);
            end
        end
    endtask

    task automatic test_branch();
        step_t s;
        add(0,0,0,0,0,0,          32'h014, 32'h010, 32'h010, 1, 0);
        add(0,0,0,0,1,32'h100,    32'h100, 32'h014, 32'h014, 1, 0);
        add(0,0,0,0,0,0,          32'h104, 32'h100, 32'h100, 1, 0);
        add(0,0,0,0,0,0,          32'h108, 32'h104, 32'h104, 1, 0);
        while (q.size() > 0) begin
            s = q.pop_front();
            stall_if = s.sif; stall_id = s.sid; flush = s.fl; new_pc_i = s.npc;
            branch_flag_i = s.br; branch_target_i = s.tgt;
            @(posedge clk); #1;
            total++;
            if ({rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o} !==
                {s.e_addr, 1'b1, s.e_pc, s.e_inst, s.e_vld, s.e_adel}) begin
                bad++;
                $display("FAIL branch: got addr=%h ce=%b pc=%h inst=%h v=%b adel=%b want addr=%h pc=%h inst=%h v=%b adel=%b",
                         rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o,
                         s.e_addr, s.e_pc, s.e_inst, s.e_vld, s.e_adel);
            end
        end
    endtask

    task automatic test_stalled_branch();
        step_t s;
        add(1,1,0,0,1,32'h200,    32'h108, 32'h104, 32'h104, 1, 0);
        add(1,1,0,0,0,0,          32'h108, 32'h104, 32'h104, 1, 0);
        add(1,1,0,0,0,0,          32'h108, 32'h104, 32'h104, 1, 0);
        add(0,0,0,0,0,0,          32'h200, 32'h108, 32'h108, 1, 0);
        add(0,0,0,0,0,0,          32'h204, 32'h200, 32'h200, 1, 0);
        while (q.size() > 0) begin
            s = q.pop_front();
            stall_if = s.sif; stall_id = s.sid; flush = s.fl; new_pc_i = s.npc;
            branch_flag_i = s.br; branch_target_i = s.tgt;
            @(posedge clk); #1;
            total++;
            if ({rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o} !==
                {s.e_addr, 1'b1, s.e_pc, s.e_inst, s.e_vld, s.e_adel}) begin
                bad++;
                $display("FAIL stalled_branch: got addr=%h ce=%b pc=%h inst=%h v=%b adel=%b want addr=%h pc=%h inst=%h v=%b adel=%b",
                         rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o,
                         s.e_addr, s.e_pc, s.e_inst, s.e_vld, s.e_adel);
            end
        end
    endtask

    task automatic test_bubble();
        step_t s;
        add(1,0,0,0,0,0,          32'h204, 32'h000, 32'h000, 0, 0);
        add(1,0,0,0,0,0,          32'h204, 32'h000, 32'h000, 0, 0);
        add(0,0,0,0,0,0,          32'h208, 32'h204, 32'h204, 1, 0);
        add(0,0,0,0,0,0,          32'h20C, 32'h208, 32'h208, 1, 0);
        while (q.size() > 0) begin
            s = q.pop_front();
            stall_if = s.sif; stall_id = s.sid; flush = s.fl; new_pc_i = s.npc;
            branch_flag_i = s.br; branch_target_i = s.tgt;
            @(posedge clk); #1;
            total++;
            if ({rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o} !==
                {s.e_addr, 1'b1, s.e_pc, s.e_inst, s.e_vld, s.e_adel}) begin
                bad++;
                $display("FAIL bubble: got addr=%h ce=%b pc=%h inst=%h v=%b adel=%b want addr=%h pc=%h inst=%h v=%b adel=%b",
                         rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o,
                         s.e_addr, s.e_pc, s.e_inst, s.e_vld, s.e_adel);
            end
        end
    endtask

    task automatic test_flush_priority();
        step_t s;
        add(1,1,1,32'h180,1,32'h300, 32'h180, 32'h000, 32'h000, 0, 0);
        add(0,0,0,0,0,0,             32'h184, 32'h180, 32'h180, 1, 0);
        add(0,0,0,0,0,0,             32'h188, 32'h184, 32'h184, 1, 0);
        while (q.size() > 0) begin
            s = q.pop_front();
            stall_if = s.sif; stall_id = s.sid; flush = s.fl; new_pc_i = s.npc;
            branch_flag_i = s.br; branch_target_i = s.tgt;
            @(posedge clk); #1;
            total++;
            if ({rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o} !==
                {s.e_addr, 1'b1, s.e_pc, s.e_inst, s.e_vld, s.e_adel}) begin
                bad++;
                $display("FAIL flush_priority: got addr=%h ce=%b pc=%h inst=%h v=%b adel=%b want addr=%h pc=%h inst=%h v=%b adel=%b",
                         rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o,
                         s.e_addr, s.e_pc, s.e_inst, s.e_vld, s.e_adel);
            end
        end
    endtask

    task automatic test_misalign_reset();
        step_t s;
        add(0,0,0,0,1,32'h102,    32'h102, 32'h188, 32'h188, 1, 0);
        add(0,0,0,0,0,0,          32'h106, 32'h102, 32'h000, 1, 1);
        add(1,1,0,0,1,32'h400,    32'h106, 32'h102, 32'h000, 1, 1);
        while (q.size() > 0) begin
            s = q.pop_front();
            stall_if = s.sif; stall_id = s.sid; flush = s.fl; new_pc_i = s.npc;
            branch_flag_i = s.br; branch_target_i = s.tgt;
            @(posedge clk); #1;
            total++;
            if ({rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o} !==
                {s.e_addr, 1'b1, s.e_pc, s.e_inst, s.e_vld, s.e_adel}) begin
                bad++;
                $display("FAIL misalign: got addr=%h ce=%b pc=%h inst=%h v=%b adel=%b want addr=%h pc=%h inst=%h v=%b adel=%b",
                         rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o,
                         s.e_addr, s.e_pc, s.e_inst, s.e_vld, s.e_adel);
            end
        end
        // Drop reset mid-cycle with a branch pending; it must be forgotten.
        branch_flag_i = 0;
        #2 rst = 1'b0;
        #1;
        total++;
        if ({rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o} !== 67'h0) begin
            bad++;
            $display("FAIL async_reset: got addr=%h ce=%b pc=%h inst=%h v=%b adel=%b want all 0",
                     rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o);
        end
        #2;
        idle_inputs();
        rst = 1'b1;
        add(0,0,0,0,0,0,          32'h000, 32'h000, 32'h000, 0, 0);
        add(0,0,0,0,0,0,          32'h004, 32'h000, 32'h000, 1, 0);
        add(0,0,0,0,0,0,          32'h008, 32'h004, 32'h004, 1, 0);
        while (q.size() > 0) begin
            s = q.pop_front();
            stall_if = s.sif; stall_id = s.sid; flush = s.fl; new_pc_i = s.npc;
            branch_flag_i = s.br; branch_target_i = s.tgt;
            @(posedge clk); #1;
            total++;
            if ({rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o} !==
                {s.e_addr, 1'b1, s.e_pc, s.e_inst, s.e_vld, s.e_adel}) begin
                bad++;
                $display("FAIL restart: got addr=%h ce=%b pc=%h inst=%h v=%b adel=%b want addr=%h pc=%h inst=%h v=%b adel=%b",
                         rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o,
                         s.e_addr, s.e_pc, s.e_inst, s.e_vld, s.e_adel);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t s;
        add(0,0,0,0,1,32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'h008, 32'h008, 1, 0);
        add(0,0,0,0,0,0,             32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1, 0);
        add(0,0,0,0,0,0,             32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0);
        add(0,0,0,0,0,0,             32'h0000_0004, 32'h0000_0000, 32'h0000_0000, 1, 0);
        add(1,0,0,0,1,32'h500,       32'h004, 32'h000, 32'h000, 0, 0);
        add(1,0,0,0,1,32'h600,       32'h004, 32'h000, 32'h000, 0, 0);
        add(0,0,0,0,0,0,             32'h600, 32'h004, 32'h004, 1, 0);
        add(0,0,0,0,0,0,             32'h604, 32'h600, 32'h600, 1, 0);
        while (q.size() > 0) begin
            s = q.pop_front();
            stall_if = s.sif; stall_id = s.sid; flush = s.fl; new_pc_i = s.npc;
            branch_flag_i = s.br; branch_target_i = s.tgt;
            @(posedge clk); #1;
            total++;
            if ({rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o} !==
                {s.e_addr, 1'b1, s.e_pc, s.e_inst, s.e_vld, s.e_adel}) begin
                bad++;
                $display("FAIL back_to_back: got addr=%h ce=%b pc=%h inst=%h v=%b adel=%b want addr=%h pc=%h inst=%h v=%b adel=%b",
                         rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o,
                         s.e_addr, s.e_pc, s.e_inst, s.e_vld, s.e_adel);
            end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_stalled_branch();
        test_bubble();
        test_flush_priority();
        test_misalign_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
